freq_div_ratio_ctrl: RTL and testbench

Requester (initiator) side of the divider ratio-update handshake. It accepts a new 10-bit divide ratio from a host over a valid/ready port and drives `ratio` and `ratio_upd_req` into `freq_div_by_n_10b`. It then runs the 4-phase req/ack protocol against that divider's `ratio_upd_ack`, with a synchronizer, timeout and range check. It sits beside the divider in the `clkin` domain and replaces bench-driven ratio updates in the integrated design.

---
 rtl/freq_div_pkg.sv | 24 ++
 rtl/freq_div_ratio_ctrl_bit_sync.sv | 24 ++
 rtl/freq_div_ratio_ctrl.sv | 163 ++++++++++++++++
 tb/tb_freq_div_ratio_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_div_pkg.sv
// Shared types and constants for the divider ratio-update controller.
package freq_div_pkg;

    localparam int RATIO_W   = 10;
    localparam int RATIO_MIN = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        REQ   = 3'd2,
        HOLD  = 3'd3,
        REL   = 3'd4,
        GAP   = 3'd5
    } ratio_ctrl_state_e;

    // Largest of three counts, used to size the shared down-counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return m;
    endfunction

endpackage

// File: rtl/freq_div_ratio_ctrl_bit_sync.sv
// Reset-able flop chain that brings an asynchronous level into the clkin domain.
module bit_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clkin,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Shift the raw input through the chain; reset clears every stage.
    always_ff @(posedge clkin) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/freq_div_ratio_ctrl.sv
// Requester side of the divider ratio-update handshake.
//
// state | meaning
// IDLE  | ready for a host ratio; out-of-range ratios pulse cfg_err
// SETUP | new ratio presented, waiting for a low ack before raising req
// REQ   | req high, waiting for ack (bounded by TIMEOUT)
// HOLD  | ack seen, req held for HOLD_CYCLES more cycles
// REL   | req low, waiting for ack to drop (bounded by TIMEOUT)
// GAP   | quiet time before the next request is accepted
module freq_div_ratio_ctrl
    import freq_div_pkg::*;
#(
    parameter int RATIO_W     = freq_div_pkg::RATIO_W,
    parameter int RATIO_MIN   = freq_div_pkg::RATIO_MIN,
    parameter int RESET_RATIO = 10,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 2,
    parameter int GAP_CYCLES  = 4,
    parameter int TIMEOUT     = 1023
) (
    input  logic               clkin,
    input  logic               rst,
    input  logic [RATIO_W-1:0] cfg_ratio,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    output logic               cfg_err,
    output logic [RATIO_W-1:0] ratio,
    output logic               ratio_upd_req,
    input  logic               ratio_upd_ack,
    output logic [RATIO_W-1:0] cur_ratio,
    output logic               busy,
    output logic               timeout
);

    localparam int CNT_W = $clog2(max3(TIMEOUT, HOLD_CYCLES, GAP_CYCLES) + 1);

    // Counter load values: a count of N cycles runs the counter from N-1 down to 0.
    localparam logic [CNT_W-1:0]   TMO_LOAD  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [RATIO_W-1:0] MIN_V     = RATIO_W'(RATIO_MIN);
    localparam logic [RATIO_W-1:0] RST_V     = RATIO_W'(RESET_RATIO);

    ratio_ctrl_state_e  state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               req_nxt;
    logic [RATIO_W-1:0] ratio_nxt, cur_ratio_nxt;
    logic               cfg_err_nxt, timeout_nxt;
    logic               ack_s;
    logic               xfer;

    bit_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clkin (clkin),
        .rst   (rst),
        .d     (ratio_upd_ack),
        .q     (ack_s)
    );

    assign cfg_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign xfer      = cfg_valid & cfg_ready;

    // State, shared counter and all registered outputs.
    always_ff @(posedge clkin) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            ratio_upd_req <= 1'b0;
            ratio         <= RST_V;
            cur_ratio     <= RST_V;
            cfg_err       <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            ratio_upd_req <= req_nxt;
            ratio         <= ratio_nxt;
            cur_ratio     <= cur_ratio_nxt;
            cfg_err       <= cfg_err_nxt;
            timeout       <= timeout_nxt;
        end
    end

    // Next-state logic; the counter is reloaded on every state change that needs it.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        req_nxt       = ratio_upd_req;
        ratio_nxt     = ratio;
        cur_ratio_nxt = cur_ratio;
        cfg_err_nxt   = 1'b0;
        timeout_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (xfer) begin
                    if (cfg_ratio < MIN_V) begin
                        cfg_err_nxt = 1'b1;
                    end else begin
                        ratio_nxt = cfg_ratio;
                        state_nxt = SETUP;
                    end
                end
            end
            SETUP: begin
                // A stale high ack from an abandoned handshake is absorbed here.
                if (!ack_s) begin
                    req_nxt   = 1'b1;
                    cnt_nxt   = TMO_LOAD;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (ack_s) begin
                    cur_ratio_nxt = ratio;
                    cnt_nxt       = HOLD_LOAD;
                    state_nxt     = HOLD;
                end else if (cnt == '0) begin
                    timeout_nxt = 1'b1;
                    req_nxt     = 1'b0;
                    cnt_nxt     = TMO_LOAD;
                    state_nxt   = REL;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    req_nxt   = 1'b0;
                    cnt_nxt   = TMO_LOAD;
                    state_nxt = REL;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            REL: begin
                if (!ack_s) begin
                    cnt_nxt   = GAP_LOAD;
                    state_nxt = GAP;
                end else if (cnt == '0) begin
                    timeout_nxt = 1'b1;
                    cnt_nxt     = GAP_LOAD;
                    state_nxt   = GAP;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                req_nxt   = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_freq_div_ratio_ctrl.sv
// Directed bench for freq_div_ratio_ctrl; the bench plays the divider's ack side.
module tb_freq_div_ratio_ctrl;

    logic       clkin;
    logic       rst;
    logic [9:0] cfg_ratio;
    logic       cfg_valid;
    logic       cfg_ready;
    logic       cfg_err;
    logic [9:0] ratio;
    logic       ratio_upd_req;
    logic       ratio_upd_ack;
    logic [9:0] cur_ratio;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    freq_div_ratio_ctrl dut (
        .clkin         (clkin),
        .rst           (rst),
        .cfg_ratio     (cfg_ratio),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_err       (cfg_err),
        .ratio         (ratio),
        .ratio_upd_req (ratio_upd_req),
        .ratio_upd_ack (ratio_upd_ack),
        .cur_ratio     (cur_ratio),
        .busy          (busy),
        .timeout       (timeout)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Full handshake for ratio r; returns in REL with ack already released.
    task automatic xfer(input logic [9:0] r, input bit keep_valid);
        int   n;
        bit   stable;
        bit   no_early;
        logic [9:0] prev;
        prev      = ratio;
        no_early  = 1'b1;
        cfg_ratio = r;
        cfg_valid = 1'b1;
        n = 0;
        while (!cfg_ready && n < 50) begin
            tick();
            if (!cfg_ready && ratio !== prev) no_early = 1'b0;
            n++;
        end
        chk("xfer_ready", cfg_ready, 1);
        chk("xfer_no_early_load", no_early, 1);
        tick();
        chk("xfer_load", ratio, r);
        if (!keep_valid) cfg_valid = 1'b0;
        n = 0;
        while (!ratio_upd_req && n < 10) begin tick(); n++; end
        chk("xfer_req_rise", ratio_upd_req, 1);
        ratio_upd_ack = 1'b1;
        stable = 1'b1;
        n = 0;
        while (ratio_upd_req && n < 20) begin
            if (ratio !== r) stable = 1'b0;
            tick();
            n++;
        end
        chk("xfer_req_fall", ratio_upd_req, 0);
        chk("xfer_ratio_stable", stable, 1);
        chk("xfer_cur_ratio", cur_ratio, r);
        ratio_upd_ack = 1'b0;
    endtask

    initial begin
        int n;
        logic [9:0] rv [10];

        rst           = 1'b1;
        cfg_ratio     = '0;
        cfg_valid     = 1'b0;
        ratio_upd_ack = 1'b0;
        ticks(3);
        chk("rst_ratio", ratio, 10);
        chk("rst_cur_ratio", cur_ratio, 10);
        chk("rst_req", ratio_upd_req, 0);
        chk("rst_err", cfg_err, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cfg_ready, 1);
        rst = 1'b0;
        tick();

        // Ratio 25 with exact handshake timing.
        cfg_ratio = 10'd25;
        cfg_valid = 1'b1;
        chk("t1_ready_pre", cfg_ready, 1);
        tick();
        cfg_valid = 1'b0;
        chk("t1_ratio_t1", ratio, 25);
        chk("t1_req_t1", ratio_upd_req, 0);
        chk("t1_busy", busy, 1);
        chk("t1_ready_busy", cfg_ready, 0);
        tick();
        chk("t1_req_t2", ratio_upd_req, 1);
        ratio_upd_ack = 1'b1;
        ticks(2);
        chk("t1_cur_before", cur_ratio, 10);
        chk("t1_req_ack_s", ratio_upd_req, 1);
        tick();
        chk("t1_cur_after", cur_ratio, 25);
        tick();
        chk("t1_req_hold", ratio_upd_req, 1);
        tick();
        chk("t1_req_fall", ratio_upd_req, 0);
        ratio_upd_ack = 1'b0;
        ticks(6);
        chk("t1_gap_ready", cfg_ready, 0);
        tick();
        chk("t1_ready_back", cfg_ready, 1);

        // Below-minimum ratios are rejected with a single pulse.
        cfg_ratio = 10'd1;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("t2_err_pulse", cfg_err, 1);
        chk("t2_ratio_kept", ratio, 25);
        chk("t2_busy", busy, 0);
        tick();
        chk("t2_err_clear", cfg_err, 0);
        cfg_ratio = 10'd0;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("t2_err_zero", cfg_err, 1);
        chk("t2_ready_zero", cfg_ready, 1);

        // Boundary ratio and a repeat of the current ratio.
        tick();
        xfer(10'd2, 1'b0);
        chk("t2_min_no_err", cfg_err, 0);
        xfer(10'd2, 1'b0);
        chk("t2_same_cur", cur_ratio, 2);

        // Ack never rises: REQ timeout.
        n = 0;
        while (!cfg_ready && n < 50) begin tick(); n++; end
        cfg_ratio = 10'd30;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        tick();
        chk("t3_req_up", ratio_upd_req, 1);
        n = 0;
        while (ratio_upd_req && n < 1100) begin tick(); n++; end
        chk("t3_req_cycles", n, 1023);
        chk("t3_timeout_pulse", timeout, 1);
        chk("t3_cur_kept", cur_ratio, 2);
        chk("t3_ratio", ratio, 30);
        n = 0;
        while (!cfg_ready && n < 50) begin
            tick();
            n++;
            if (n == 1) chk("t3_timeout_clear", timeout, 0);
        end
        chk("t3_ready_gap", n, 5);

        // Ack stuck high: SETUP waits, then REL times out.
        ratio_upd_ack = 1'b1;
        ticks(3);
        cfg_ratio = 10'd40;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("t4_ratio", ratio, 40);
        ticks(5);
        chk("t4_setup_req", ratio_upd_req, 0);
        chk("t4_setup_busy", busy, 1);
        ratio_upd_ack = 1'b0;
        ticks(2);
        chk("t4_req_still_low", ratio_upd_req, 0);
        tick();
        chk("t4_req_up", ratio_upd_req, 1);
        ratio_upd_ack = 1'b1;
        ticks(3);
        chk("t4_cur", cur_ratio, 40);
        ticks(2);
        chk("t4_req_fall", ratio_upd_req, 0);
        n = 0;
        while (!timeout && n < 1100) begin tick(); n++; end
        chk("t4_rel_cycles", n, 1023);
        n = 0;
        while (!cfg_ready && n < 50) begin tick(); n++; end
        chk("t4_ready_gap", n, 4);
        ratio_upd_ack = 1'b0;
        ticks(3);

        // Reset during HOLD.
        cfg_ratio = 10'd15;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        tick();
        ratio_upd_ack = 1'b1;
        ticks(3);
        chk("t5_cur_hold", cur_ratio, 15);
        chk("t5_req_hold", ratio_upd_req, 1);
        rst = 1'b1;
        tick();
        chk("t5_req", ratio_upd_req, 0);
        chk("t5_ratio", ratio, 10);
        chk("t5_cur", cur_ratio, 10);
        chk("t5_ready", cfg_ready, 1);
        chk("t5_busy", busy, 0);
        ratio_upd_ack = 1'b0;
        tick();
        rst = 1'b0;
        ticks(3);

        // Back-to-back random ratios with cfg_valid held throughout.
        for (int i = 0; i < 10; i++) rv[i] = 10'($urandom_range(40, 10));
        for (int i = 0; i < 10; i++) xfer(rv[i], 1'b1);
        cfg_valid = 1'b0;
        n = 0;
        while (!cfg_ready && n < 50) begin tick(); n++; end
        ticks(3);
        chk("t6_idle_after", busy, 0);
        chk("t6_last_cur", cur_ratio, rv[9]);
        chk("t6_last_ratio", ratio, rv[9]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
